// File: rtl/xf100_ifu_ibuf_pkg.sv
// ---------------------------------------------------------------------------
// xf100_ifu_ibuf_pkg
//   Shared sizes and types for the IFU instruction buffer.
//   Instruction/pc widths and buffer geometry come from the XF100 define set.
//   Each define gets a default here if it is not already set, so the block
//   builds without any external defines.
//   Optional feature macro used by the buffer: XF100_IBUF_BYPASS_EN.
// ---------------------------------------------------------------------------
`ifndef XF100_INSTR_SIZE
`define XF100_INSTR_SIZE 32
`endif
`ifndef XF100_PC_SIZE
`define XF100_PC_SIZE 32
`endif
`ifndef XF100_IBUF_DEPTH
`define XF100_IBUF_DEPTH 4
`endif
`ifndef XF100_IBUF_AW
`define XF100_IBUF_AW 2
`endif

package xf100_ifu_ibuf_pkg;

  localparam int INSTR_W    = `XF100_INSTR_SIZE;
  localparam int PC_W       = `XF100_PC_SIZE;
  localparam int IBUF_DEPTH = `XF100_IBUF_DEPTH;
  localparam int IBUF_AW    = `XF100_IBUF_AW;

  // One buffered fetch result.
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } ibuf_entry_t;

endpackage

// File: rtl/xf100_ibuf_ptr.sv
// ---------------------------------------------------------------------------
// xf100_ibuf_ptr
//   Read/write pointers and occupancy count for the instruction buffer.
//   Pointers are AW bits wide and wrap naturally because DEPTH = 2**AW.
//   Ports:
//     clk, rst      clock, asynchronous active-high reset
//     push, pop     qualified write / read of one entry this cycle
//     flush         clears both pointers and the count; beats push/pop
//     wr_ptr,rd_ptr current write / read slot
//     count         occupancy 0..DEPTH
//     full, empty   count == DEPTH / count == 0
// ---------------------------------------------------------------------------
module xf100_ibuf_ptr #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  output logic [AW-1:0] wr_ptr,
  output logic [AW-1:0] rd_ptr,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;

  // Next-state for pointers and count.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = {AW{1'b0}};
      rd_ptr_d = {AW{1'b0}};
      count_d  = {(AW+1){1'b0}};
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {(AW+1){1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign wr_ptr = wr_ptr_q;
  assign rd_ptr = rd_ptr_q;
  assign count  = count_q;
  assign full   = (count_q == (AW+1)'(DEPTH));
  assign empty  = (count_q == {(AW+1){1'b0}});

endmodule

// File: rtl/xf100_ifu_ibuf.sv
// ---------------------------------------------------------------------------
// xf100_ifu_ibuf
//   Instruction buffer between the IFU and the decoder: a DEPTH-entry FIFO of
//   {instr, pc} pairs with valid/ready on both sides and a one-cycle flush.
//   Optional macro XF100_IBUF_BYPASS_EN: when the buffer is empty an incoming
//   pair is presented to the decoder in the same cycle (and not stored if the
//   decoder takes it).
//   Ports:
//     clk, rst                 clock, asynchronous active-high reset
//     ibuf_i_valid/instr/pc    pair from the IFU
//     ibuf_o_ready             buffer can accept (state and flush only)
//     ibuf_o_valid/instr/pc    head entry to the decoder; data 0 when invalid
//     ibuf_i_ready             decoder takes the head this cycle
//     ibuf_i_flush             discard everything held
//     ibuf_o_count             occupancy 0..DEPTH
// ---------------------------------------------------------------------------
module xf100_ifu_ibuf
  import xf100_ifu_ibuf_pkg::*;
#(
  parameter int DEPTH = IBUF_DEPTH,
  parameter int AW    = IBUF_AW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ibuf_i_valid,
  input  logic [INSTR_W-1:0] ibuf_i_instr,
  input  logic [PC_W-1:0]    ibuf_i_pc,
  output logic               ibuf_o_ready,
  output logic               ibuf_o_valid,
  output logic [INSTR_W-1:0] ibuf_o_instr,
  output logic [PC_W-1:0]    ibuf_o_pc,
  input  logic               ibuf_i_ready,
  input  logic               ibuf_i_flush,
  output logic [AW:0]        ibuf_o_count
);

  ibuf_entry_t   mem_q [DEPTH];
  ibuf_entry_t   wr_entry;
  ibuf_entry_t   head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          bypass;
  logic          ptr_push;
  logic          ptr_pop;

  xf100_ibuf_ptr #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ptr (
    .clk    (clk),
    .rst    (rst),
    .push   (ptr_push),
    .pop    (ptr_pop),
    .flush  (ibuf_i_flush),
    .wr_ptr (wr_ptr),
    .rd_ptr (rd_ptr),
    .count  (ibuf_o_count),
    .full   (full),
    .empty  (empty)
  );

  // Handshake qualification, bypass selection and head output muxing.
  always_comb begin
    wr_entry     = '{instr: ibuf_i_instr, pc: ibuf_i_pc};
    ibuf_o_ready = !full && !ibuf_i_flush;
    push         = ibuf_i_valid && ibuf_o_ready;
    bypass       = 1'b0;
`ifdef XF100_IBUF_BYPASS_EN
    bypass       = empty && ibuf_i_valid && !ibuf_i_flush;
`endif
    ibuf_o_valid = (!empty && !ibuf_i_flush) || bypass;
    if (!ibuf_o_valid) begin
      head = '0;
    end else if (bypass) begin
      head = wr_entry;
    end else begin
      head = mem_q[rd_ptr];
    end
    pop      = ibuf_o_valid && ibuf_i_ready;
    // A bypassed pair taken by the decoder never touches the storage.
    ptr_push = push && !(bypass && ibuf_i_ready);
    ptr_pop  = pop && !bypass;
  end

  assign ibuf_o_instr = head.instr;
  assign ibuf_o_pc    = head.pc;

  // Storage array; deliberately not reset, occupancy lives in the pointers.
  always_ff @(posedge clk) begin
    if (ptr_push) begin
      mem_q[wr_ptr] <= wr_entry;
    end
  end

endmodule

// File: tb/tb_xf100_ifu_ibuf.sv
// ---------------------------------------------------------------------------
// tb_xf100_ifu_ibuf
//   Self-checking bench for xf100_ifu_ibuf. A queue holds the pairs the
//   buffer should be holding; every cycle the bench predicts ready, valid,
//   head data and count from that queue, compares, then updates the queue
//   with the push/pop/flush that the clock edge will perform.
// ---------------------------------------------------------------------------
module tb_xf100_ifu_ibuf;
  import xf100_ifu_ibuf_pkg::*;

  logic               clk;
  logic               rst;
  logic               ibuf_i_valid;
  logic [INSTR_W-1:0] ibuf_i_instr;
  logic [PC_W-1:0]    ibuf_i_pc;
  logic               ibuf_o_ready;
  logic               ibuf_o_valid;
  logic [INSTR_W-1:0] ibuf_o_instr;
  logic [PC_W-1:0]    ibuf_o_pc;
  logic               ibuf_i_ready;
  logic               ibuf_i_flush;
  logic [IBUF_AW:0]   ibuf_o_count;

  int errors = 0;
  int checks = 0;
  int max_cnt = 0;
  ibuf_entry_t sb_q[$];

  xf100_ifu_ibuf dut (
    .clk          (clk),
    .rst          (rst),
    .ibuf_i_valid (ibuf_i_valid),
    .ibuf_i_instr (ibuf_i_instr),
    .ibuf_i_pc    (ibuf_i_pc),
    .ibuf_o_ready (ibuf_o_ready),
    .ibuf_o_valid (ibuf_o_valid),
    .ibuf_o_instr (ibuf_o_instr),
    .ibuf_o_pc    (ibuf_o_pc),
    .ibuf_i_ready (ibuf_i_ready),
    .ibuf_i_flush (ibuf_i_flush),
    .ibuf_o_count (ibuf_o_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One cycle: drive inputs after the falling edge, check outputs against the
  // scoreboard before the rising edge, then advance the scoreboard.
  task automatic step(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                      input logic rdy, input logic fl);
    int          cnt;
    logic        e_ready, e_valid, bypass_m, push_m, pop_m;
    ibuf_entry_t e_head;
    @(negedge clk);
    ibuf_i_valid = v;
    ibuf_i_instr = INSTR_W'(instr);
    ibuf_i_pc    = PC_W'(pc);
    ibuf_i_ready = rdy;
    ibuf_i_flush = fl;
    #1;
    cnt      = sb_q.size();
    e_ready  = (cnt != IBUF_DEPTH) && !fl;
    e_valid  = (cnt > 0) && !fl;
    e_head   = '0;
    bypass_m = 1'b0;
    if (e_valid) e_head = sb_q[0];
`ifdef XF100_IBUF_BYPASS_EN
    if (cnt == 0 && v && !fl) begin
      bypass_m = 1'b1;
      e_valid  = 1'b1;
      e_head   = '{instr: INSTR_W'(instr), pc: PC_W'(pc)};
    end
`endif
    check_val("ready", 64'(ibuf_o_ready), 64'(e_ready));
    check_val("valid", 64'(ibuf_o_valid), 64'(e_valid));
    check_val("instr", 64'(ibuf_o_instr), 64'(e_head.instr));
    check_val("pc",    64'(ibuf_o_pc),    64'(e_head.pc));
    check_val("count", 64'(ibuf_o_count), 64'(cnt));
    if (cnt > max_cnt) max_cnt = cnt;
    push_m = v && e_ready;
    pop_m  = e_valid && rdy;
    if (fl) begin
      sb_q.delete();
    end else if (!(bypass_m && push_m && pop_m)) begin
      if (pop_m) void'(sb_q.pop_front());
      if (push_m) sb_q.push_back('{instr: INSTR_W'(instr), pc: PC_W'(pc)});
    end
  endtask

  initial begin
    rst = 1'b1;
    ibuf_i_valid = 1'b0;
    ibuf_i_instr = '0;
    ibuf_i_pc    = '0;
    ibuf_i_ready = 1'b0;
    ibuf_i_flush = 1'b0;
    #12;
    // Reset state, checked while reset is still held.
    check_val("rst_valid", 64'(ibuf_o_valid), 64'd0);
    check_val("rst_count", 64'(ibuf_o_count), 64'd0);
    check_val("rst_ready", 64'(ibuf_o_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;

    // 1: two pushes with decoder stalled, then drain.
    step(1'b1, 32'h00000013, 32'h0, 1'b0, 1'b0);
    step(1'b1, 32'h00100093, 32'h4, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);  // count 2, head 0x13/0x0
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);  // pop head
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);  // 0x00100093/0x4 shown and popped
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // 2: fill, hold off a 5th, pop one, ready returns.
    for (int i = 0; i < 4; i++) step(1'b1, 32'hA000 + 32'(i), 32'h100 + 32'(i * 4), 1'b0, 1'b0);
    step(1'b1, 32'hDEAD, 32'h200, 1'b0, 1'b0);  // full: held off
    step(1'b1, 32'hDEAD, 32'h200, 1'b1, 1'b0);  // full + pop: still no push
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);       // count 3, ready 1
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);       // empty: ready ignored

    // 3: stream 10 pairs with decoder always ready.
    max_cnt = 0;
    for (int i = 0; i < 10; i++) step(1'b1, 32'h1000 + 32'(i), 32'(i * 4), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    check_val("stream_maxcnt_le2", 64'(max_cnt <= 2), 64'd1);
    check_val("stream_drained", 64'(ibuf_o_count), 64'd0);

    // 4: flush with count 3 together with valid and ready.
    for (int i = 0; i < 3; i++) step(1'b1, 32'hB000 + 32'(i), 32'h300 + 32'(i * 4), 1'b0, 1'b0);
    step(1'b1, 32'hBEEF, 32'h400, 1'b1, 1'b1);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);  // count 0, nothing stored
    step(1'b1, 32'hC000, 32'h500, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);  // head must be 0xC000, not flushed pair

    // 5: asynchronous reset with count 2.
    step(1'b1, 32'hD000, 32'h600, 1'b0, 1'b0);
    step(1'b1, 32'hD001, 32'h604, 1'b0, 1'b0);
    @(negedge clk);
    ibuf_i_valid = 1'b0;
    ibuf_i_ready = 1'b0;
    #1;
    check_val("pre_rst_count", 64'(ibuf_o_count), 64'd2);
    rst = 1'b1;
    #1;
    check_val("async_rst_valid", 64'(ibuf_o_valid), 64'd0);
    check_val("async_rst_count", 64'(ibuf_o_count), 64'd0);
    check_val("async_rst_pc",    64'(ibuf_o_pc),    64'd0);
    sb_q.delete();
    @(negedge clk);
    rst = 1'b0;

    // 6: empty buffer, decoder ready, single pair.
    step(1'b1, 32'h00200113, 32'h8, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Random traffic against the scoreboard.
    for (int i = 0; i < 200; i++)
      step(1'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 15) == 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
